// File: rtl/sfx_sequencer.sv
// sfx_sequencer: square-wave beep/win/lose jingle generator paced by codec sample requests.
// Optional mute input is compiled in when SFX_MUTE_EN is defined.
module sfx_sequencer #(
  parameter int SAMPLE_RATE  = 48000,
  parameter int BEEP_SAMPLES = 4800,
  parameter int NOTE_SAMPLES = 7200,
  parameter int AMPLITUDE    = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_sound,
  input  logic [1:0]        game_state,
  input  logic              sample_req,
`ifdef SFX_MUTE_EN
  input  logic              mute,
`endif
  output logic signed [15:0] sample,
  output logic              sample_valid,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, BEEP, WIN_N0, WIN_N1, WIN_N2, LOSE_N0, LOSE_N1} state_t;
  localparam logic [7:0] HP_BEEP = 8'(SAMPLE_RATE / (2 * 880));
  localparam logic [7:0] HP_C5 = 8'(SAMPLE_RATE / (2 * 523));
  localparam logic [7:0] HP_E5 = 8'(SAMPLE_RATE / (2 * 659));
  localparam logic [7:0] HP_G5 = 8'(SAMPLE_RATE / (2 * 784));
  localparam logic [7:0] HP_G4 = 8'(SAMPLE_RATE / (2 * 392));
  localparam logic [7:0] HP_C4 = 8'(SAMPLE_RATE / (2 * 262));
  localparam logic [15:0] BEEP_LAST = 16'(BEEP_SAMPLES - 1);
  localparam logic [15:0] NOTE_LAST = 16'(NOTE_SAMPLES - 1);
  localparam logic signed [15:0] AMP = 16'(AMPLITUDE);
  state_t state_q, state_d, eff_state, next_note;
  logic [15:0] dur_q, dur_d, eff_dur, len_last;
  logic [7:0] ph_q, ph_d, eff_ph, hp;
  logic pol_q, pol_d, eff_pol;
  logic [1:0] prev_state_q;
  logic prev_play_q;
  logic signed [15:0] sample_q, sample_d;
  logic valid_q, valid_d, busy_q, busy_d;
  logic beep_ev, win_ev, lose_ev, restart, active, ph_wrap, dur_end, muted;
`ifdef SFX_MUTE_EN
  assign muted = mute;
`else
  assign muted = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      dur_q        <= '0;
      ph_q         <= '0;
      pol_q        <= 1'b0;
      prev_state_q <= 2'b00;
      prev_play_q  <= 1'b0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dur_q        <= dur_d;
      ph_q         <= ph_d;
      pol_q        <= pol_d;
      prev_state_q <= game_state;
      prev_play_q  <= play_sound;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  // Events restart the note first, so a coincident request plays index 0 of the new note.
  always_comb begin
    beep_ev   = play_sound & ~prev_play_q;
    win_ev    = (game_state == 2'b10) & (prev_state_q != 2'b10);
    lose_ev   = (game_state == 2'b11) & (prev_state_q != 2'b11);
    restart   = win_ev | lose_ev | (beep_ev & (state_q == IDLE || state_q == BEEP));
    eff_state = win_ev ? WIN_N0 : lose_ev ? LOSE_N0 : restart ? BEEP : state_q;
    eff_dur   = restart ? '0 : dur_q;
    eff_ph    = restart ? '0 : ph_q;
    eff_pol   = restart ? 1'b0 : pol_q;
    hp        = eff_state == BEEP ? HP_BEEP : eff_state == WIN_N0 ? HP_C5 :
                eff_state == WIN_N1 ? HP_E5 : eff_state == WIN_N2 ? HP_G5 :
                eff_state == LOSE_N0 ? HP_G4 : HP_C4;
    len_last  = eff_state == BEEP ? BEEP_LAST : NOTE_LAST;
    next_note = eff_state == WIN_N0 ? WIN_N1 : eff_state == WIN_N1 ? WIN_N2 :
                eff_state == LOSE_N0 ? LOSE_N1 : IDLE;
    active    = sample_req & (eff_state != IDLE);
    ph_wrap   = eff_ph == hp - 8'd1;
    dur_end   = eff_dur == len_last;
    state_d   = active && dur_end ? next_note : eff_state;
    dur_d     = active ? (dur_end ? '0 : eff_dur + 16'd1) : eff_dur;
    ph_d      = active ? (dur_end || ph_wrap ? '0 : eff_ph + 8'd1) : eff_ph;
    pol_d     = active ? (dur_end ? 1'b0 : eff_pol ^ ph_wrap) : eff_pol;
  end
  always_comb begin
    sample_d = sample_req ? (active && !muted ? (eff_pol ? -AMP : AMP) : '0) : sample_q;
    valid_d  = sample_req;
    busy_d   = state_d != IDLE;
  end
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: scoreboard bench for sfx_sequencer against a note-list reference model.
module tb_sfx_sequencer;
  localparam int BEEP_N = 60;
  localparam int NOTE_N = 90;
  localparam int A = 8192;
  logic clk = 0, reset = 1, play_sound = 0, sample_req = 0;
  logic [1:0] game_state = 2'b00;
  logic signed [15:0] sample;
  logic sample_valid, busy;
`ifdef SFX_MUTE_EN
  logic mute = 0;
`endif
  sfx_sequencer #(.SAMPLE_RATE(48000), .BEEP_SAMPLES(BEEP_N), .NOTE_SAMPLES(NOTE_N), .AMPLITUDE(A)) dut (
    .clk(clk), .reset(reset), .play_sound(play_sound), .game_state(game_state),
    .sample_req(sample_req),
`ifdef SFX_MUTE_EN
    .mute(mute),
`endif
    .sample(sample), .sample_valid(sample_valid), .busy(busy));
  always #5 clk = ~clk;
  typedef struct {int s; bit b; int c;} exp_t;
  exp_t q[$];
  int nc = 0, nf = 0, cyc = 0;
  int m_hp[$];
  int m_idx = 0, m_kind = 0;
  logic m_pp = 0;
  logic [1:0] m_ps = 2'b00;
  task automatic chk(input string name, input int act, input int exp);
    nc++;
    if (act != exp) begin
      nf++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Expected sample for position k of a tone with half-period hp: high for hp, low for hp, repeat.
  task automatic step(input bit rq, input bit ps, input logic [1:0] gs);
    int s;
    @(negedge clk);
    sample_req = rq; play_sound = ps; game_state = gs;
    if (gs == 2'b10 && m_ps != 2'b10) begin m_hp = '{45, 36, 30}; m_kind = 2; m_idx = 0; end
    else if (gs == 2'b11 && m_ps != 2'b11) begin m_hp = '{61, 91}; m_kind = 2; m_idx = 0; end
    else if (ps && !m_pp && m_kind != 2) begin m_hp = '{27}; m_kind = 1; m_idx = 0; end
    if (rq) begin
      s = 0;
      if (m_kind != 0) begin
        s = ((m_idx / m_hp[0]) % 2) ? -A : A;
        m_idx++;
        if (m_idx == (m_kind == 1 ? BEEP_N : NOTE_N)) begin
          void'(m_hp.pop_front());
          m_idx = 0;
          if (m_hp.size() == 0) m_kind = 0;
        end
      end
`ifdef SFX_MUTE_EN
      if (mute) s = 0;
`endif
      q.push_back('{s, m_kind != 0, cyc});
    end
    m_pp = ps; m_ps = gs;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1; sample_req = 0;
    q.delete(); m_hp.delete(); m_idx = 0; m_kind = 0; m_pp = 0; m_ps = 2'b00;
    #1;
    chk("reset_sample", sample, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    reset = 0;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!reset && sample_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("sample", int'(sample), e.s);
        chk("busy", busy, e.b);
        chk("valid_latency", cyc - e.c, 1);
      end
    end
    if (!reset && q.size() > 0 && cyc - q[0].c > 1) begin
      chk("missing_valid", 0, 1);
      void'(q.pop_front());
    end
  end
  initial begin
    do_reset();
    for (int i = 0; i < 10; i++) begin step(1, 0, 2'b00); step(0, 0, 2'b00); end
    for (int i = 0; i < 5; i++) step(0, 1, 2'b00);
    for (int i = 0; i < 100; i++) step(1, 0, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b01);
    step(0, 0, 2'b10);
    for (int i = 0; i < 290; i++) step(1, 0, 2'b10);
    step(0, 0, 2'b01);
    step(0, 1, 2'b01);
    for (int i = 0; i < 20; i++) step(1, 0, 2'b01);
    step(1, 0, 2'b11);
    for (int i = 0; i < 120; i++) step(1, 0, 2'b11);
    step(0, 1, 2'b11);
    for (int i = 0; i < 80; i++) step(1, i % 7 == 0, 2'b11);
    step(0, 0, 2'b01);
    step(0, 0, 2'b10);
    for (int i = 0; i < 120; i++) step(1, 0, 2'b10);
    game_state = 2'b01;
    do_reset();
    step(1, 0, 2'b01);
    step(0, 0, 2'b01);
    step(0, 0, 2'b10);
    for (int i = 0; i < 100; i++) begin step(1, 0, 2'b10); step(i % 3 == 0, 0, 2'b10); end
    begin
      logic ps = 0;
      logic [1:0] gs = 2'b10;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 19) == 0) ps = ~ps;
        if ($urandom_range(0, 299) == 0) gs = 2'($urandom_range(0, 3));
`ifdef SFX_MUTE_EN
        if ($urandom_range(0, 49) == 0) mute = ~mute;
`endif
        step($urandom_range(0, 9) < 6, ps, gs);
      end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Sound-effect generator downstream of the game FSM. Consumes the FSM's play_sound pulse and game_state. Produces a signed square-wave PCM sample stream for the audio codec interface, paced by the codec's per-sample request:
- short beep on each rod-change tick;
- three-note ascending jingle on entry to Win;
- two-note descending jingle on entry to Lose.

Parameters:
SAMPLE_RATE, 48000, codec sample rate in Hz; sets tone half-periods.
BEEP_SAMPLES, 4800, beep length in samples (100 ms).
NOTE_SAMPLES, 7200, length of each jingle note in samples (150 ms).
AMPLITUDE, 8192, square-wave peak magnitude; 16-bit signed positive value.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
play_sound  in  1  beep trigger; rising edge detected internally
game_state  in  2  00 Start, 01 Play, 10 Win, 11 Lose
sample_req  in  1  one-cycle pulse from codec requesting the next sample
sample  out  16  signed PCM sample, two's complement
sample_valid  out  1  one-cycle pulse, one cycle after sample_req
busy  out  1  high while any sound is active

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high. Reset forces:
  - sample=0, sample_valid=0, busy=0;
  - FSM to IDLE;
  - prev_state=2'b00, prev_play=0;
  - all counters to 0.
- Event detection, every clk:
  - BEEP_EV = play_sound & ~prev_play.
  - WIN_EV = (game_state==2'b10) & (prev_state!=2'b10).
  - LOSE_EV = (game_state==2'b11) & (prev_state!=2'b11).
  - prev_* registered every cycle.
- Half-periods, in samples, integer-truncated, computed from SAMPLE_RATE: HP(f)=SAMPLE_RATE/(2*f). At default these are:
  - beep 880 Hz: 27
  - C5 523: 45
  - E5 659: 36
  - G5 784: 30
  - G4 392: 61
  - C4 262: 91
- States: IDLE, BEEP, WIN_N0, WIN_N1, WIN_N2, LOSE_N0, LOSE_N1.
- Event priority:
  - WIN_EV/LOSE_EV from any state: enter WIN_N0/LOSE_N0 and restart the sound. A new jingle preempts any current sound.
  - BEEP_EV in IDLE or BEEP: enter/restart BEEP.
  - BEEP_EV is ignored in any jingle state.
  - An event takes effect on the cycle it is detected. If it coincides with sample_req, the restarted note supplies that sample as its index 0.
- Note counters:
  - Counters dur_cnt (16-bit) and ph_cnt (8-bit) advance only on sample_req.
  - On (re)start: dur_cnt=0, ph_cnt=0, polarity=+.
  - On each sample_req in an active state, emit polarity*AMPLITUDE. Then:
    - ph_cnt increments; when it reaches HP-1, ph_cnt wraps to 0 and polarity toggles;
    - dur_cnt increments; when it reaches length-1, advance to the next note (counters reset, polarity +) or to IDLE after the last note.
  - Length is BEEP_SAMPLES in BEEP and NOTE_SAMPLES in jingle states.
- Output sequences:
  - WIN: WIN_N0 C5, WIN_N1 E5, WIN_N2 G5, then IDLE.
  - LOSE: LOSE_N0 G4, LOSE_N1 C4, then IDLE.
  - IDLE: sample_req yields sample=0 with sample_valid.
- Handshake:
  - sample_valid asserts exactly one cycle after every sample_req, active or idle.
  - sample updates only with sample_valid and is held between requests.
  - sample_req held high on consecutive cycles counts as one request per cycle.
- busy is high in every state except IDLE. It is registered with the state.
- Reset mid-sound aborts immediately; no tail samples.

Optional Feature:
SFX_MUTE_EN:
- Defined: adds input port mute (1 bit). While mute=1, sample is forced to 0; sequencing, busy and sample_valid are unaffected.
- Undefined: no mute port; behaviour as above.

Test Plan:
- Reset, then 10 sample_req pulses in IDLE -> 10 sample_valid pulses, each one cycle later, all sample=0, busy=0.
- play_sound held high 5 cycles, then 100 sample_req (BEEP_SAMPLES=60) -> the play_sound hold triggers exactly one beep:
  - samples 0..26 = +8192, 27..53 = -8192, 54..59 = +8192;
  - samples 60..99 = 0;
  - busy falls after sample 59.
- game_state 01->10, NOTE_SAMPLES=90 -> first 90 samples have half-period 45, next 90 have 36, next 90 have 30; then 0, busy=0.
- Beep active, then game_state 01->11 mid-beep -> the next sample starts G4 at +8192 (61 high, 61 low); a play_sound edge during LOSE_N1 is ignored.
- Reset asserted mid-WIN_N1 between requests -> next sample_req yields 0, busy=0. A later 01->10 transition restarts the jingle from WIN_N0.
- SFX_MUTE_EN defined, mute=1 during beep -> sample=0 throughout, busy=1 for exactly BEEP_SAMPLES requests.
